move_request_gen: RTL and testbench

//  Front end that produces the one-hot up/down/left/right move commands consumed by the 2048 game FSM.

---
 rtl/move_req_pkg.sv | 33 +++
 rtl/btn_debounce.sv | 65 ++++++
 rtl/move_request_gen.sv | 139 +++++++++++++
 tb/tb_move_request_gen.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/move_req_pkg.sv
// Shared constants for the move request front end: one-hot FSM state
// encodings, 2-bit direction codes and the press priority resolver.
package move_req_pkg;

   // FSM states, one-hot
   localparam logic [3:0] IDLE    = 4'b0001;
   localparam logic [3:0] PENDING = 4'b0010;
   localparam logic [3:0] ISSUE   = 4'b0100;
   localparam logic [3:0] RELEASE = 4'b1000;

   // Direction codes, also the bit index of each button in press/level vectors
   localparam logic [1:0] DIR_UP    = 2'd0;
   localparam logic [1:0] DIR_DOWN  = 2'd1;
   localparam logic [1:0] DIR_LEFT  = 2'd2;
   localparam logic [1:0] DIR_RIGHT = 2'd3;

   // Resolve simultaneous press events: up > down > left > right.
   // Only meaningful when at least one bit of ev is set.
   function automatic logic [1:0] prio_dir(input logic [3:0] ev);
      logic [1:0] d;
      if (ev[0]) begin
         d = DIR_UP;
      end else if (ev[1]) begin
         d = DIR_DOWN;
      end else if (ev[2]) begin
         d = DIR_LEFT;
      end else begin
         d = DIR_RIGHT;
      end
      return d;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button channel: 2-FF synchroniser, stability counter that
// accepts a level change only after DEBOUNCE_CYCLES consecutive differing
// samples, and a registered rising-edge (press) detector.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic Clk,
   input  logic Reset,
   input  logic btn_raw,
   output logic level,
   output logic press
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic             level_q, level_d;
   logic             press_q, press_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Next-state: synchroniser shift, stability count, level flip and edge
   always_comb begin
      sync1_d = btn_raw;
      sync2_d = sync1_q;
      level_d = level_q;
      cnt_d   = CNT_ZERO;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = ~level_q;
            cnt_d   = CNT_ZERO;
         end else begin
            cnt_d   = cnt_q + CNT_ONE;
         end
      end else begin
         // Input agrees with the accepted level: any partial count was a bounce
         cnt_d = CNT_ZERO;
      end
      press_d = level_d & ~level_q;
   end

   // State registers with asynchronous reset
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         press_q <= 1'b0;
         cnt_q   <= CNT_ZERO;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         level_q <= level_d;
         press_q <= press_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level = level_q;
   assign press = press_q;

endmodule

// File: rtl/move_request_gen.sv
// Move request generator: debounces four buttons, picks the highest
// priority press, holds it until the game FSM waits, then issues a single
// one-cycle one-hot move pulse and waits for all buttons to be released.
module move_request_gen
   import move_req_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 500000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       btn_left,
   input  logic       btn_right,
   input  logic       q_Wait,
   input  logic       q_Win,
   input  logic       q_Lose,
   output logic       up,
   output logic       down,
   output logic       left,
   output logic       right,
   output logic       busy,
   output logic [1:0] last_dir
);

   logic [3:0] level_vec;
   logic [3:0] press_vec;
   logic [3:0] btn_vec;

   logic [3:0] state_q, state_d;
   logic [1:0] dir_q, dir_d;
   logic [1:0] last_dir_q, last_dir_d;
   logic       up_q, up_d;
   logic       down_q, down_d;
   logic       left_q, left_d;
   logic       right_q, right_d;
   logic       busy_q, busy_d;

   assign btn_vec = {btn_right, btn_left, btn_down, btn_up};

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_db
         btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
         ) u_db (
            .Clk     (Clk),
            .Reset   (Reset),
            .btn_raw (btn_vec[gi]),
            .level   (level_vec[gi]),
            .press   (press_vec[gi])
         );
      end
   endgenerate

   // FSM transitions plus direction capture; new presses only matter in IDLE
   always_comb begin
      state_d    = state_q;
      dir_d      = dir_q;
      last_dir_d = last_dir_q;
      case (state_q)
         IDLE: begin
            if (press_vec != 4'b0000) begin
               dir_d   = prio_dir(press_vec);
               state_d = PENDING;
            end else begin
               state_d = IDLE;
            end
         end
         PENDING: begin
            // Game over drops the request before a waiting FSM can take it
            if (q_Win || q_Lose) begin
               state_d = RELEASE;
            end else if (q_Wait) begin
               state_d = ISSUE;
            end else begin
               state_d = PENDING;
            end
         end
         ISSUE: begin
            last_dir_d = dir_q;
            state_d    = RELEASE;
         end
         RELEASE: begin
            // No auto-repeat: every button must be seen released first
            if (level_vec == 4'b0000) begin
               state_d = IDLE;
            end else begin
               state_d = RELEASE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Output decode from the next state so the pulse is registered and one-hot
   always_comb begin
      up_d    = (state_d == ISSUE) && (dir_d == DIR_UP);
      down_d  = (state_d == ISSUE) && (dir_d == DIR_DOWN);
      left_d  = (state_d == ISSUE) && (dir_d == DIR_LEFT);
      right_d = (state_d == ISSUE) && (dir_d == DIR_RIGHT);
      busy_d  = (state_d != IDLE);
   end

   // State and output registers with asynchronous reset
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= IDLE;
         dir_q      <= DIR_UP;
         last_dir_q <= DIR_UP;
         up_q       <= 1'b0;
         down_q     <= 1'b0;
         left_q     <= 1'b0;
         right_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         dir_q      <= dir_d;
         last_dir_q <= last_dir_d;
         up_q       <= up_d;
         down_q     <= down_d;
         left_q     <= left_d;
         right_q    <= right_d;
         busy_q     <= busy_d;
      end
   end

   assign up       = up_q;
   assign down     = down_q;
   assign left     = left_q;
   assign right    = right_q;
   assign busy     = busy_q;
   assign last_dir = last_dir_q;

endmodule

// File: tb/tb_move_request_gen.sv
// Self-checking bench for move_request_gen with a short debounce window.
// A behavioural model (sample-window debounce + request lifecycle) predicts
// every output each cycle; scenario tasks add targeted pulse-count checks.
module tb_move_request_gen;

   localparam int DB = 4;

   logic       Clk = 1'b0;
   logic       Reset = 1'b1;
   logic [3:0] btn = 4'b0000;          // [0]=up [1]=down [2]=left [3]=right
   logic       q_Wait = 1'b0;
   logic       q_Win = 1'b0;
   logic       q_Lose = 1'b0;
   logic       up, down, left, right, busy;
   logic [1:0] last_dir;

   int checks = 0;
   int errors = 0;

   // model state
   int hist [4][DB+2];
   bit m_lvl [4];
   bit m_press [4];
   int m_mode;     // 0 idle, 1 holding request, 2 pulsing, 3 waiting for release
   int m_dir;
   int m_last;

   always #5 Clk = ~Clk;

   move_request_gen #(.DEBOUNCE_CYCLES(DB), .CNT_W(4)) dut (
      .Clk(Clk), .Reset(Reset),
      .btn_up(btn[0]), .btn_down(btn[1]), .btn_left(btn[2]), .btn_right(btn[3]),
      .q_Wait(q_Wait), .q_Win(q_Win), .q_Lose(q_Lose),
      .up(up), .down(down), .left(left), .right(right),
      .busy(busy), .last_dir(last_dir)
   );

   task automatic model_reset();
      for (int b = 0; b < 4; b++) begin
         for (int k = 0; k < DB + 2; k++) hist[b][k] = 0;
         m_lvl[b] = 0;
         m_press[b] = 0;
      end
      m_mode = 0;
      m_dir = 0;
      m_last = 0;
   endtask

   // One active clock edge of the model, using inputs driven before the edge
   task automatic model_edge();
      bit all_low;
      bit stable;
      if (Reset) begin
         model_reset();
      end else begin
         all_low = 1;
         for (int b = 0; b < 4; b++) if (m_lvl[b]) all_low = 0;
         case (m_mode)
            0: begin
               for (int b = 3; b >= 0; b--) begin
                  if (m_press[b]) begin
                     m_dir = b;
                     m_mode = 1;
                  end
               end
            end
            1: begin
               if (q_Win || q_Lose) m_mode = 3;
               else if (q_Wait) m_mode = 2;
            end
            2: begin
               m_last = m_dir;
               m_mode = 3;
            end
            default: begin
               if (all_low) m_mode = 0;
            end
         endcase
         // level accepted once the synchronised input (2 samples old) has
         // differed from it for DB consecutive samples
         for (int b = 0; b < 4; b++) begin
            for (int k = DB + 1; k > 0; k--) hist[b][k] = hist[b][k-1];
            hist[b][0] = int'(btn[b]);
            stable = 1;
            for (int k = 2; k <= DB + 1; k++) if (hist[b][k] == int'(m_lvl[b])) stable = 0;
            m_press[b] = stable && !m_lvl[b];
            if (stable) m_lvl[b] = !m_lvl[b];
         end
      end
   endtask

   function automatic logic [6:0] exp_vec();
      logic [3:0] p;
      logic [1:0] l;
      p = 4'b0000;
      if (m_mode == 2) p[3 - m_dir] = 1'b1;
      l = 2'(m_last);
      return {p, (m_mode != 0), l};
   endfunction

   task automatic tick();
      @(posedge Clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if ({up, down, left, right, busy, last_dir} !== 7'b0) begin
            errors++;
            $display("FAIL reset_hold cyc %0d: got %b expected %b", i, {up, down, left, right, busy, last_dir}, 7'b0);
         end
      end
      Reset = 1'b0;
      for (int i = 0; i < 100; i++) begin
         tick();
         checks++;
         if ({up, down, left, right, busy, last_dir} !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle cyc %0d: got %b expected %b", i, {up, down, left, right, busy, last_dir}, exp_vec());
         end
      end
   endtask

   task automatic test_bounce();
      int busy_seen = 0;
      for (int i = 0; i < 40; i++) begin
         btn[0] = (i < 20) ? ((i / 2) % 2 == 0) : 1'b0;
         tick();
         if (busy) busy_seen++;
         checks++;
         if ({up, down, left, right, busy, last_dir} !== exp_vec()) begin
            errors++;
            $display("FAIL bounce cyc %0d: got %b expected %b", i, {up, down, left, right, busy, last_dir}, exp_vec());
         end
      end
      checks++;
      if (busy_seen !== 0) begin
         errors++;
         $display("FAIL bounce_busy: busy cycles %0d expected 0", busy_seen);
      end
   endtask

   task automatic test_single_press();
      int lcnt = 0;
      int other = 0;
      q_Wait = 1'b1;
      btn = 4'b0100;
      for (int i = 0; i < 50; i++) begin
         if (i == 20) btn = 4'b0000;
         tick();
         if (left) lcnt++;
         if (up || down || right) other++;
         checks++;
         if ({up, down, left, right, busy, last_dir} !== exp_vec()) begin
            errors++;
            $display("FAIL single_press cyc %0d: got %b expected %b", i, {up, down, left, right, busy, last_dir}, exp_vec());
         end
      end
      checks++;
      if (lcnt !== 1 || other !== 0) begin
         errors++;
         $display("FAIL single_press_count: left %0d other %0d expected 1 and 0", lcnt, other);
      end
      checks++;
      if (last_dir !== 2'd2 || busy !== 1'b0) begin
         errors++;
         $display("FAIL single_press_end: last_dir %0d busy %b expected 2 and 0", last_dir, busy);
      end
   endtask

   task automatic test_pending_hold();
      int pulses = 0;
      bit got_busy = 0;
      q_Wait = 1'b0;
      btn = 4'b0010;
      for (int i = 0; i < 20 && !got_busy; i++) begin
         tick();
         got_busy = busy;
         checks++;
         if ({up, down, left, right, busy, last_dir} !== exp_vec()) begin
            errors++;
            $display("FAIL pending_wait cyc %0d: got %b expected %b", i, {up, down, left, right, busy, last_dir}, exp_vec());
         end
      end
      checks++;
      if (!got_busy) begin
         errors++;
         $display("FAIL pending_busy_timeout: busy 0 expected 1 within 20 cycles");
      end
      for (int i = 0; i < 50; i++) begin
         tick();
         if (up || down || left || right) pulses++;
         checks++;
         if ({up, down, left, right, busy, last_dir} !== exp_vec()) begin
            errors++;
            $display("FAIL pending_hold cyc %0d: got %b expected %b", i, {up, down, left, right, busy, last_dir}, exp_vec());
         end
      end
      checks++;
      if (pulses !== 0) begin
         errors++;
         $display("FAIL pending_no_pulse: pulses %0d expected 0", pulses);
      end
      q_Wait = 1'b1;
      tick();
      checks++;
      if ({up, down, left, right} !== 4'b0100) begin
         errors++;
         $display("FAIL pending_issue: got %b expected 0100", {up, down, left, right});
      end
      btn = 4'b0000;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if ({up, down, left, right, busy, last_dir} !== exp_vec()) begin
            errors++;
            $display("FAIL pending_release cyc %0d: got %b expected %b", i, {up, down, left, right, busy, last_dir}, exp_vec());
         end
      end
   endtask

   task automatic test_priority();
      int ucnt = 0;
      int rcnt = 0;
      q_Wait = 1'b1;
      btn = 4'b1001;
      for (int i = 0; i < 60; i++) begin
         if (i == 20) btn = 4'b0000;
         if (i == 35) btn = 4'b1000;
         tick();
         if (up) ucnt++;
         if (right && i < 35) rcnt++;
         checks++;
         if ({up, down, left, right, busy, last_dir} !== exp_vec()) begin
            errors++;
            $display("FAIL priority cyc %0d: got %b expected %b", i, {up, down, left, right, busy, last_dir}, exp_vec());
         end
      end
      checks++;
      if (ucnt !== 1 || rcnt !== 0) begin
         errors++;
         $display("FAIL priority_count: up %0d right %0d expected 1 and 0", ucnt, rcnt);
      end
      checks++;
      if (last_dir !== 2'd3) begin
         errors++;
         $display("FAIL priority_repress: last_dir %0d expected 3", last_dir);
      end
      btn = 4'b0000;
      for (int i = 0; i < 15; i++) tick();
   endtask

   task automatic test_lose_and_reset();
      int pulses = 0;
      int ucnt = 0;
      q_Wait = 1'b0;
      btn = 4'b0100;
      for (int i = 0; i < 12; i++) tick();
      q_Lose = 1'b1;
      for (int i = 0; i < 25; i++) begin
         if (i == 3) q_Lose = 1'b0;
         if (i == 3) q_Wait = 1'b1;
         if (i == 8) btn = 4'b0000;
         tick();
         if (up || down || left || right) pulses++;
         checks++;
         if ({up, down, left, right, busy, last_dir} !== exp_vec()) begin
            errors++;
            $display("FAIL lose cyc %0d: got %b expected %b", i, {up, down, left, right, busy, last_dir}, exp_vec());
         end
      end
      checks++;
      if (pulses !== 0 || busy !== 1'b0) begin
         errors++;
         $display("FAIL lose_drop: pulses %0d busy %b expected 0 and 0", pulses, busy);
      end
      btn = 4'b0001;
      for (int i = 0; i < 4; i++) tick();
      Reset = 1'b1;
      model_reset();
      #1;
      checks++;
      if ({up, down, left, right, busy, last_dir} !== 7'b0) begin
         errors++;
         $display("FAIL async_reset: got %b expected %b", {up, down, left, right, busy, last_dir}, 7'b0);
      end
      tick();
      tick();
      Reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (up) ucnt++;
         checks++;
         if ({up, down, left, right, busy, last_dir} !== exp_vec()) begin
            errors++;
            $display("FAIL post_reset cyc %0d: got %b expected %b", i, {up, down, left, right, busy, last_dir}, exp_vec());
         end
      end
      checks++;
      if (ucnt !== 1) begin
         errors++;
         $display("FAIL post_reset_press: up pulses %0d expected 1", ucnt);
      end
      btn = 4'b0000;
      for (int i = 0; i < 15; i++) tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 1500; i++) begin
         for (int b = 0; b < 4; b++) if ($urandom_range(0, 9) == 0) btn[b] = ~btn[b];
         q_Wait = ($urandom_range(0, 3) != 0);
         q_Win  = ($urandom_range(0, 15) == 0);
         q_Lose = ($urandom_range(0, 15) == 0);
         tick();
         checks++;
         if ({up, down, left, right, busy, last_dir} !== exp_vec()) begin
            errors++;
            $display("FAIL random cyc %0d: got %b expected %b", i, {up, down, left, right, busy, last_dir}, exp_vec());
         end
         checks++;
         if ($countones({up, down, left, right}) > 1) begin
            errors++;
            $display("FAIL random_onehot cyc %0d: got %b expected at most one bit", i, {up, down, left, right});
         end
      end
      q_Win = 1'b0;
      q_Lose = 1'b0;
   endtask

   initial begin
      model_reset();
      test_reset();
      test_bounce();
      test_single_press();
      test_pending_hold();
      test_priority();
      test_lose_and_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
